// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator family: controller state encoding and
// the one-hot {GT,EQ,LT} result codes.
package comparator_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   // Bit order is {GT, EQ, LT}; a valid result is exactly one-hot.
   typedef logic [2:0] result_t;

   localparam result_t RES_NONE = 3'b000;
   localparam result_t RES_GT   = 3'b100;
   localparam result_t RES_EQ   = 3'b010;
   localparam result_t RES_LT   = 3'b001;

   function automatic result_t pack_result(input logic gt, input logic eq, input logic lt);
      return {gt, eq, lt};
   endfunction

endpackage

// File: rtl/comparator_1bit_cell.sv
// Combinational 1-bit unsigned magnitude comparator.
module comparator_1bit_cell (
   input  logic A,
   input  logic B,
   output logic GT,
   output logic EQ,
   output logic LT
);

   assign GT = A & ~B;
   assign LT = ~A & B;
   assign EQ = ~(A ^ B);

endmodule

// File: rtl/serial_mag_comparator_ctrl.sv
// Bit-serial magnitude comparator: walks A and B MSB first through one 1-bit
// cell, stopping at the first differing bit, and reports GT/EQ/LT with done.
module serial_mag_comparator_ctrl
   import comparator_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             GT,
   output logic             EQ,
   output logic             LT
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

   state_t           state, state_n;
   result_t          res, res_n;
   logic             load, step;
   logic [WIDTH-1:0] sh_a, sh_b;
   logic [IDX_W-1:0] idx;
   logic             cell_gt, cell_eq, cell_lt;

   // The operand MSB position always holds the bit currently under test.
   comparator_1bit_cell u_cell (
      .A  (sh_a[WIDTH-1]),
      .B  (sh_b[WIDTH-1]),
      .GT (cell_gt),
      .EQ (cell_eq),
      .LT (cell_lt)
   );

   always_comb begin
      state_n = state;
      res_n   = res;
      load    = 1'b0;
      step    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               res_n   = RES_NONE;
               state_n = COMPARE;
            end
         end
         COMPARE: begin
            if (!cell_eq) begin
               res_n   = pack_result(cell_gt, 1'b0, cell_lt);
               state_n = DONE;
            end else if (idx == '0) begin
               res_n   = RES_EQ;
               state_n = DONE;
            end else begin
               step = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         res   <= RES_NONE;
      end else begin
         state <= state_n;
         res   <= res_n;
      end
   end

   // Operand copies and bit index are only meaningful while COMPARE runs,
   // so they carry no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         sh_a <= A;
         sh_b <= B;
         idx  <= IDX_TOP;
      end else if (step) begin
         sh_a <= sh_a << 1;
         sh_b <= sh_b << 1;
         idx  <= idx - 1'b1;
      end
   end

   assign busy         = (state == COMPARE) || (state == DONE);
   assign done         = (state == DONE);
   assign {GT, EQ, LT} = res;

endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
// Scoreboard bench for serial_mag_comparator_ctrl (WIDTH=8) plus a WIDTH=1 build.
module tb_serial_mag_comparator_ctrl;

   localparam int W = 8;

   typedef struct {
      int         c0;
      int         dcyc;
      logic [2:0] res;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         busy, done, GT, EQ, LT;

   logic         start1 = 1'b0;
   logic [0:0]   a1 = '0;
   logic [0:0]   b1 = '0;
   logic         busy1, done1, gt1, eq1, lt1;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   logic [2:0] held = 3'b000;

   serial_mag_comparator_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .GT(GT), .EQ(EQ), .LT(LT)
   );

   serial_mag_comparator_ctrl #(.WIDTH(1)) dut_w1 (
      .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
      .busy(busy1), .done(done1), .GT(gt1), .EQ(eq1), .LT(lt1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endfunction

   // Reference model: compare latency is the number of bits examined down to
   // and including the highest differing bit.
   function automatic int exp_k(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x;
      x = a ^ b;
      for (int i = W - 1; i >= 0; i--)
         if (x[i]) return W - i;
      return W;
   endfunction

   function automatic logic [2:0] exp_res(input logic [W-1:0] a, input logic [W-1:0] b);
      if (a > b) return 3'b100;
      if (a == b) return 3'b010;
      return 3'b001;
   endfunction

   // Monitor: pops the scoreboard on done and checks busy/result every cycle.
   always @(negedge clk) begin
      logic exp_busy;
      exp_busy = (q.size() > 0) && (cyc > q[0].c0) && (cyc <= q[0].dcyc);
      check("busy", busy, exp_busy);
      if (q.size() > 0 && cyc == q[0].dcyc) begin
         check("done_pulse", done, 1'b1);
         check("result", {GT, EQ, LT}, q[0].res);
         held = q[0].res;
         void'(q.pop_front());
      end else begin
         check("done_quiet", done, 1'b0);
         if (q.size() > 0 && cyc > q[0].c0)
            check("result_cleared", {GT, EQ, LT}, 3'b000);
         else
            check("result_held", {GT, EQ, LT}, held);
      end
      if (rst) begin
         held = 3'b000;
         q.delete();
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
      exp_t e;
      e.c0   = cyc;
      e.dcyc = cyc + exp_k(a, b) + 1;
      e.res  = exp_res(a, b);
      start = 1'b1;
      A = a;
      B = b;
      q.push_back(e);
      while (cyc <= e.dcyc) begin
         next_cyc();
         if (!keep) begin
            A = W'($urandom);
            B = W'($urandom);
            start = (cyc <= e.dcyc) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
   endtask

   task automatic w1_run(input logic a, input logic b, input logic [2:0] req);
      start1 = 1'b1;
      a1 = a;
      b1 = b;
      next_cyc();
      start1 = 1'b0;
      a1 = ~a;
      b1 = ~b;
      check("w1_busy_c1", busy1, 1'b1);
      check("w1_done_c1", done1, 1'b0);
      next_cyc();
      check("w1_done_c2", done1, 1'b1);
      check("w1_result", {gt1, eq1, lt1}, req);
      next_cyc();
      check("w1_done_c3", done1, 1'b0);
      check("w1_busy_c3", busy1, 1'b0);
      check("w1_hold", {gt1, eq1, lt1}, req);
   endtask

   initial begin
      exp_t e;
      logic [W-1:0] ra, rb;
      repeat (3) next_cyc();
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_result", {GT, EQ, LT}, 3'b000);
      rst = 1'b0;
      next_cyc();

      issue(8'hA5, 8'h25, 1'b0);
      issue(8'h3C, 8'h3D, 1'b0);
      issue(8'h5A, 8'h5A, 1'b0);
      repeat (2) next_cyc();

      // Second start during COMPARE must be ignored.
      e.c0 = cyc; e.dcyc = cyc + 5; e.res = 3'b100;
      start = 1'b1; A = 8'h10; B = 8'h01;
      q.push_back(e);
      next_cyc();
      start = 1'b0;
      next_cyc();
      start = 1'b1; A = 8'h00; B = 8'hFF;
      next_cyc();
      start = 1'b0;
      while (cyc <= e.dcyc) next_cyc();
      repeat (12) next_cyc();

      // Reset in cycle 3 discards the in-flight compare.
      e.c0 = cyc; e.dcyc = cyc + exp_k(8'h01, 8'h02) + 1; e.res = 3'b001;
      start = 1'b1; A = 8'h01; B = 8'h02;
      q.push_back(e);
      next_cyc();
      start = 1'b0;
      next_cyc();
      next_cyc();
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_result", {GT, EQ, LT}, 3'b000);
      repeat (10) next_cyc();

      // start together with rst: rst wins.
      rst = 1'b1; start = 1'b1; A = 8'h80; B = 8'h7F;
      next_cyc();
      rst = 1'b0; start = 1'b0;
      repeat (3) next_cyc();
      issue(8'h80, 8'h7F, 1'b0);
      repeat (3) next_cyc();

      // start held high: back-to-back acceptance every k+2 cycles.
      repeat (3) issue(8'hF0, 8'hF1, 1'b1);
      start = 1'b0;
      repeat (3) next_cyc();

      repeat (60) begin
         ra = W'($urandom);
         case ($urandom_range(0, 3))
            0: rb = W'($urandom);
            1: rb = ra;
            2: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
            default: rb = ra ^ W'(1);
         endcase
         repeat ($urandom_range(0, 2)) next_cyc();
         issue(ra, rb, 1'b0);
      end
      repeat (4) next_cyc();

      w1_run(1'b1, 1'b0, 3'b100);
      w1_run(1'b0, 1'b1, 3'b001);
      w1_run(1'b1, 1'b1, 3'b010);
      next_cyc();

      check("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_mag_comparator_ctrl.md
# serial_mag_comparator_ctrl

Sequencer that compares two WIDTH-bit unsigned operands by streaming them, MSB first, through a single 1-bit magnitude comparator cell, one bit per clock. It sits between a requester that issues start/operands and the shared 1-bit comparator datapath. It stops early at the first differing bit and reports GT/EQ/LT with a done pulse.

## Interface
- WIDTH, 8, operand width in bits; legal range 1 to 32.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- A  input  WIDTH  operand A, unsigned; sampled on the accepting edge.
- B  input  WIDTH  operand B, unsigned; sampled on the accepting edge.
- busy  output  1  high while in COMPARE or DONE.
- done  output  1  one-cycle pulse; result valid in that cycle.
- GT  output  1  A > B; registered, one-hot with EQ and LT when valid.
- EQ  output  1  A == B.
- LT  output  1  A < B.

## Operation
- FSM states: IDLE, COMPARE, DONE.
- IDLE, start=1:
  - Latch A and B into shift registers.
  - Set bit index to WIDTH-1.
  - Clear GT/EQ/LT to 000.
  - Go to COMPARE.
- IDLE, start=0: remain in IDLE.
- COMPARE: drive the current bit of A and B into the 1-bit cell each cycle.
  - Cell GT or LT: register that result and go to DONE.
  - Cell EQ and index>0: decrement index, stay in COMPARE.
  - Cell EQ and index==0: register EQ=1 and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Result hold: GT/EQ/LT hold their value after DONE until the next accepted start clears them.
- start is ignored in COMPARE and DONE; no queuing.
- A and B may change freely after acceptance; only the latched copies are used.
- Arithmetic: plain unsigned compare, no sign handling.
- Index counter width is max(1, clog2(WIDTH)); WIDTH=1 must work with a single COMPARE cycle.

## Timing
- Reset values: state=IDLE, busy=0, done=0, GT=0, EQ=0, LT=0; shift registers and index are don't-care.
- Reset mid-operation: rst overrides everything. The next cycle shows reset values, with no done pulse and the in-flight result discarded.
- start and rst together: rst wins.
- Latency, counted from the accepting edge (cycle 0):
  - Let k = WIDTH - p, where p is the index of the highest differing bit.
  - k COMPARE cycles occupy cycles 1..k; done is high in cycle k+1.
  - Equal operands: k = WIDTH, so done is high in cycle WIDTH+1.
- Minimum turnaround: the next start is accepted in the cycle after done (IDLE). Peak issue rate is one request per k+2 cycles.
- busy goes high in cycle 1 and low in the cycle after done.

## Structure
- Shared package/header `comparator_pkg`: FSM state encodings (IDLE=2'd0, COMPARE=2'd1, DONE=2'd2), plus the result-code constants shared with other comparator blocks.
- Sub-module `comparator_1bit_cell`: purely combinational 1-bit magnitude comparator with inputs A, B and outputs GT, EQ, LT, instantiated once.
- Controller RTL holds the FSM, the two shift registers (or a mux on the index), the index counter and the result registers.

## Test plan
- WIDTH=8, A=8'hA5, B=8'h25, start for one cycle -> single COMPARE cycle; done in cycle 2 with GT=1, EQ=0, LT=0; busy high in cycles 1–2.
- A=8'h3C, B=8'h3D -> 8 COMPARE cycles; done in cycle 9 with LT=1.
- A=B=8'h5A -> done in cycle 9 with EQ=1. Then change A/B to 8'h00/8'hFF during compare -> result still EQ.
- Start A=8'h10, B=8'h01. In cycle 2 (COMPARE) pulse start with A=8'h00, B=8'hFF -> second request ignored; done with GT=1 from the first request, and no second done.
- Start A=8'h01, B=8'h02, assert rst in cycle 3 -> cycle 4 shows busy=0, done=0, GT/EQ/LT=000, and no done ever appears. Then start A=8'h80, B=8'h7F -> done in cycle 2 with GT=1.
- start held high permanently with A=8'hF0, B=8'hF1 -> accepted only in IDLE; done pulses repeat every 10 cycles with LT=1. WIDTH=1 build: A=1, B=0 -> done in cycle 2 with GT=1.
